// File: rtl/front_panel_loader.sv
// Front-panel memory preloader: buffers (addr, data) words and sequences the
// switch register, load-PC and deposit buttons, then starts the CPU at START_PC.
module front_panel_loader #(
    parameter int                WORD_W     = 12,
    parameter int                HOLD_CYC   = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] START_PC   = 12'o0200
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              run_led,
    output logic [WORD_W-1:0] sw_out,
    output logic              load_pc_btn,
    output logic              deposit_btn,
    output logic              run_sw,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SW, S_PRESS, S_RELEASE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {ACT_LPC, ACT_DEP, ACT_FINAL} act_t;

    entry_t            mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push, pop, empty;
    entry_t            head, cur;

    state_t            state, state_nx;
    act_t              act;
    logic [PW-1:0]     phase_cnt;
    logic              phase_end, in_phase;
    logic              pc_valid, run_seen;
    logic [WORD_W-1:0] next_pc;

    assign load_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = load_valid && load_ready;
    assign head       = mem[rd_ptr];
    assign phase_end  = (phase_cnt == PW'(HOLD_CYC - 1));
    assign in_phase   = (state == S_SW) || (state == S_PRESS) || (state == S_RELEASE);

    // Storage carries no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {load_last, load_addr, load_data};
    end

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        sw_out      = '0;
        load_pc_btn = 1'b0;
        deposit_btn = 1'b0;
        run_sw      = (state == S_RUN);
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
        if (in_phase)
            sw_out = (act == ACT_DEP) ? cur.data : ((act == ACT_FINAL) ? START_PC : cur.addr);
        if (state == S_PRESS) begin
            deposit_btn = (act == ACT_DEP);
            load_pc_btn = (act != ACT_DEP);
        end
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_FETCH;
            S_FETCH: if (!empty) begin
                pop      = 1'b1;
                state_nx = S_SW;
            end
            S_SW:    if (phase_end) state_nx = S_PRESS;
            S_PRESS: if (phase_end) state_nx = S_RELEASE;
            S_RELEASE: if (phase_end) begin
                if (act == ACT_FINAL)                state_nx = S_RUN;
                else if (act == ACT_DEP && !cur.last) state_nx = S_FETCH;
                else                                 state_nx = S_SW;
            end
            S_RUN:   if (run_seen && !run_led) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= S_IDLE;
            act        <= ACT_LPC;
            cur        <= '0;
            phase_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pc_valid   <= 1'b0;
            next_pc    <= '0;
            word_count <= '0;
            run_seen   <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            phase_cnt <= (in_phase && state_nx == state) ? phase_cnt + PW'(1) : '0;
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    word_count <= '0;
                    pc_valid   <= 1'b0;
                    run_seen   <= 1'b0;
                end
                // A press of load-PC is skipped when deposit auto-increment already lands here.
                S_FETCH: if (pop) begin
                    cur <= head;
                    act <= (pc_valid && head.addr == next_pc) ? ACT_DEP : ACT_LPC;
                end
                S_RELEASE: if (phase_end) begin
                    case (act)
                        ACT_LPC: begin
                            act      <= ACT_DEP;
                            pc_valid <= 1'b1;
                            next_pc  <= cur.addr;
                        end
                        ACT_DEP: begin
                            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
                            next_pc <= next_pc + WORD_W'(1);
                            if (cur.last) act <= ACT_FINAL;
                        end
                        default: ;
                    endcase
                end
                S_RUN: if (run_led) run_seen <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/front_panel_loader.md
# front_panel_loader

Synthesizable replacement for the bench-side Load PC / Deposit button sequencing used to preload PDP-8 memory before a run. Accepts (address, data) words from a host over a valid/ready stream, buffers them in a small FIFO, and drives the Front_Panel switch register, load-PC and deposit buttons with programmable hold times. It skips redundant load-PC presses when addresses are consecutive, exploiting deposit auto-increment. After the last word it loads the start PC, sets the run switch and reports completion when the CPU halts.

## Interface
- WORD_W, 12, switch/address/data width
- HOLD_CYC, 10, cycles per button phase (switch setup, press, release); must be ≥1
- FIFO_DEPTH, 4, input buffer entries; power of two, ≥2
- START_PC, 12'o0200, PC loaded before run

- clock  in  1  system clock, all logic on rising edge
- resetN  in  1  synchronous active-low reset
- load_valid  in  1  host word valid
- load_ready  out  1  FIFO can accept (= not full)
- load_addr  in  WORD_W  target address
- load_data  in  WORD_W  word to deposit
- load_last  in  1  marks final word of image
- start  in  1  one-cycle pulse, begins session (ignored unless IDLE or DONE)
- run_led  in  1  CPU running indicator from Front_Panel
- sw_out  out  WORD_W  switch register to Front_Panel
- load_pc_btn  out  1  load-PC button
- deposit_btn  out  1  deposit button
- run_sw  out  1  run switch
- busy  out  1  session in progress (not IDLE/DONE)
- done  out  1  CPU halted after run
- word_count  out  16  deposits completed this session, saturates at 16'hFFFF

## Operation
- Reset values: sw_out 0, load_pc_btn 0, deposit_btn 0, run_sw 0, busy 0, done 0, word_count 0, FIFO empty, load_ready 1, pc_valid 0, state IDLE.
- FIFO: push when load_valid && load_ready; entry = {last, addr, data}. Words may be pushed in any state, including before start. No push when full.
- States: IDLE, FETCH, SW, PRESS, RELEASE, RUN, DONE. An action register selects LPC, DEP or FINAL_LPC.
- IDLE/DONE with start high → FETCH. Entry clears word_count, pc_valid and done.
- FETCH: waits while FIFO empty. Otherwise pops in that cycle and latches the entry. If pc_valid && addr == next_pc, action = DEP; else action = LPC. → SW.
- SW: sw_out = addr (LPC/FINAL_LPC) or data (DEP); buttons low.
- PRESS: sw_out held; the selected button is high (deposit_btn for DEP, load_pc_btn otherwise).
- RELEASE: sw_out held; buttons low.
- Each of SW, PRESS and RELEASE lasts exactly HOLD_CYC cycles, counted by a single phase counter.
- End of RELEASE:
  - LPC → SW with action DEP; set pc_valid and next_pc = addr.
  - DEP → word_count++. next_pc = next_pc + 1 mod 2^WORD_W (7777 wraps to 0000). If latched last → SW with FINAL_LPC (sw_out = START_PC); else → FETCH.
  - FINAL_LPC → RUN.
- RUN: run_sw = 1. Falling edge of run_led after it has been seen high → DONE. run_sw stays 1.
- DONE: done = 1, busy = 0, run_sw = 0. Further start begins a new session, and pc_valid is cleared.
- start while busy: ignored.
- Only one button is ever high at a time; buttons are never high in SW or RELEASE.
- resetN low at any cycle, including mid-press: all state returns to reset values on that edge; buffered words are discarded.

## Timing
- start → FETCH on the next edge.
- FETCH pop → SW on the next cycle.
- Contiguous word: 1 + 3·HOLD_CYC cycles from FETCH to the next FETCH.
- Non-contiguous word: 1 + 6·HOLD_CYC cycles.
- Final sequence adds 3·HOLD_CYC cycles before run_sw rises.
- load_ready is combinational from FIFO count. A pop in FETCH frees an entry that is visible on the next cycle.

## Test plan
- Reset: hold resetN low 3 cycles → every output equals its reset value; load_ready = 1.
- Contiguous image, HOLD_CYC=10: push (0200,1234), (0201,4321), (0202,7000,last), then start.
  - Exactly one load_pc_btn pulse (sw_out = 0200) and three deposit_btn pulses (sw_out 1234, 4321, 7000), each pulse 10 cycles wide.
  - Final load_pc_btn with sw_out = 0200, then run_sw = 1; word_count = 3.
- Gap: push 0200 then 0400 (last) → two data load-PC pulses (0200, 0400) plus the final pulse.
- Wrap: push 7777 then 0000 (last) → one data load-PC pulse only; the second deposit writes to 0000.
- Backpressure: with FIFO_DEPTH=4, offer 5 words before start → load_ready falls after the 4th push. The 5th word is accepted the cycle after the first FETCH pop; all 5 words are deposited in order.
- Reset mid-PRESS, then completion:
  - Assert resetN = 0 during deposit_btn high → next edge deposit_btn = 0, busy = 0, FIFO empty.
  - A later session: drive run_led high then low → done = 1 the cycle after the fall, run_sw = 0.
